// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds the default sizing, the fixed requester indices and the
// round-robin pointer type plus its update helper.
package regfile_wb_arbiter_pkg;

  localparam int NREQ     = 3;   // write requesters (fixed)
  localparam int AW       = 3;   // register address width
  localparam int DW       = 32;  // data width
  localparam int RF_DEPTH = 8;   // architectural registers

  localparam int REQ_ALU  = 0;
  localparam int REQ_LSU  = 1;
  localparam int REQ_DBG  = 2;

  // Round-robin search start: index of the requester with top priority.
  typedef logic [1:0] ptr_t;

  // Pointer moves to the requester after the one just granted; holds otherwise.
  function automatic ptr_t next_ptr(input logic [2:0] grant, input ptr_t cur);
    ptr_t nxt;
    nxt = cur;
    if (grant[REQ_ALU]) nxt = ptr_t'(REQ_LSU);
    if (grant[REQ_LSU]) nxt = ptr_t'(REQ_DBG);
    if (grant[REQ_DBG]) nxt = ptr_t'(REQ_ALU);
    return nxt;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb3.sv
// Three-way round-robin arbiter (purely combinational).
// Ports:
//   valid - request vector, one bit per requester
//   ptr   - requester searched first (0..2), search wraps 2->0
//   grant - one-hot grant, all zero when nothing is valid
module rr_arb3
  import regfile_wb_arbiter_pkg::*;
(
  input  logic [2:0] valid,
  input  ptr_t       ptr,
  output logic [2:0] grant
);

  always_comb begin
    // NOTE: default assignment first so every path drives grant and no latch is inferred.
    grant = 3'b000;
    case (ptr)
      2'd1: begin
        if      (valid[1]) grant = 3'b010;
        else if (valid[2]) grant = 3'b100;
        else if (valid[0]) grant = 3'b001;
      end
      2'd2: begin
        if      (valid[2]) grant = 3'b100;
        else if (valid[0]) grant = 3'b001;
        else if (valid[1]) grant = 3'b010;
      end
      default: begin
        if      (valid[0]) grant = 3'b001;
        else if (valid[1]) grant = 3'b010;
        else if (valid[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with load scoreboard.
// Three requesters (ALU, LSU, debug) compete for the single write port;
// the winner is registered onto rf_we/rf_wa/rf_wd one cycle later.
// A busy bit per register tracks loads in flight and stalls issue on
// RAW/WAW hazards against them or against the write currently on the port.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   req_valid/req_addr/req_data     - per-requester write request (packed)
//   req_ready                       - per-requester grant, combinational
//   iss_valid/iss_long/iss_rd/rs1/rs2 - issue attempt and its register fields
//   iss_stall                       - issue must not proceed this cycle
//   rf_we/rf_wa/rf_wd               - registered register-file write port
//   sb_busy                         - pending-load vector, bit 0 always 0
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NREQ = regfile_wb_arbiter_pkg::NREQ,
  parameter int AW   = regfile_wb_arbiter_pkg::AW,
  parameter int DW   = regfile_wb_arbiter_pkg::DW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  input  logic                iss_valid,
  input  logic                iss_long,
  input  logic [AW-1:0]       iss_rd,
  input  logic [AW-1:0]       iss_rs1,
  input  logic [AW-1:0]       iss_rs2,
  output logic                iss_stall,
  output logic                rf_we,
  output logic [AW-1:0]       rf_wa,
  output logic [DW-1:0]       rf_wd,
  output logic [RF_DEPTH-1:0] sb_busy
);

  ptr_t                ptr;
  logic [2:0]          grant;
  logic                grant_any;
  logic [AW-1:0]       g_addr;
  logic [DW-1:0]       g_data;
  logic [AW-1:0]       lsu_addr;
  logic [RF_DEPTH-1:0] busy;
  logic [RF_DEPTH-1:0] set_mask;
  logic [RF_DEPTH-1:0] clr_mask;
  logic                fwd_hit;

  rr_arb3 u_arb (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // No grant is given while reset is held.
  assign req_ready = reset ? '0 : grant;
  assign grant_any = |req_ready;

  always_comb begin
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        g_addr = req_addr[i*AW +: AW];
        g_data = req_data[i*DW +: DW];
      end
    end
  end

  assign lsu_addr = req_addr[REQ_LSU*AW +: AW];

  // Register 0 is hardwired; masking bit 0 here keeps it out of every stall term.
  assign sb_busy = {busy[RF_DEPTH-1:1], 1'b0};

  // The write sitting on the port this cycle is not yet visible to readers.
  assign fwd_hit   = rf_we && (rf_wa != '0) && ((rf_wa == iss_rs1) || (rf_wa == iss_rs2));
  assign iss_stall = !reset && iss_valid &&
                     (sb_busy[iss_rs1] || sb_busy[iss_rs2] || sb_busy[iss_rd] || fwd_hit);

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid && iss_long && (iss_rd != '0) && !iss_stall) set_mask[iss_rd]   = 1'b1;
    if (req_ready[REQ_LSU] && (lsu_addr != '0))                clr_mask[lsu_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      busy  <= '0;
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (grant_any) begin
        ptr   <= next_ptr(req_ready, ptr);
        rf_wa <= g_addr;
        rf_wd <= g_data;
      end
      // Writes to register 0 are accepted but never reach the file.
      rf_we <= grant_any && (g_addr != '0);
      // Set wins over clear when a new load targets the register being retired.
      busy  <= (busy & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations, plus a behavioural model compared against the DUT every cycle.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [8:0]  req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        iss_valid, iss_long;
  logic [2:0]  iss_rd, iss_rs1, iss_rs2;
  logic        iss_stall;
  logic        rf_we;
  logic [2:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [7:0]  sb_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .iss_valid (iss_valid),
    .iss_long  (iss_long),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall),
    .rf_we     (rf_we),
    .rf_wa     (rf_wa),
    .rf_wd     (rf_wd),
    .sb_busy   (sb_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [31:0] d);
    req_addr[i*3 +: 3]  = a;
    req_data[i*32 +: 32] = d;
  endtask

  // ---------------- behavioural model ----------------
  int          m_ptr = 0;
  bit          m_busy [8];
  bit          m_we = 0;
  int          m_wa = 0;
  logic [31:0] m_wd = '0;

  function automatic bit busy_at(input int i);
    return (i != 0) && m_busy[i];
  endfunction

  initial begin
    int          g;
    int          idx;
    logic [2:0]  e_ready;
    bit          e_stall;
    logic [7:0]  e_sb;
    logic [2:0]  a;
    @(posedge clk);
    forever begin
      @(negedge clk);
      g = -1;
      if (!reset) begin
        for (int k = 0; k < 3; k++) begin
          idx = (m_ptr + k) % 3;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      e_ready = '0;
      if (g >= 0) e_ready[g] = 1'b1;
      e_stall = 0;
      if (!reset && iss_valid)
        e_stall = busy_at(int'(iss_rs1)) || busy_at(int'(iss_rs2)) || busy_at(int'(iss_rd)) ||
                  (m_we && m_wa != 0 && (m_wa == int'(iss_rs1) || m_wa == int'(iss_rs2)));
      e_sb = '0;
      for (int i = 1; i < 8; i++) e_sb[i] = m_busy[i];

      check("model_ready", req_ready, e_ready);
      check("model_stall", iss_stall, e_stall);
      check("model_we", rf_we, m_we);
      check("model_busy", sb_busy, e_sb);
      if (m_we) begin
        check("model_wa", rf_wa, m_wa);
        check("model_wd", rf_wd, m_wd);
      end

      if (reset) begin
        m_ptr = 0; m_we = 0; m_wa = 0; m_wd = '0;
        for (int i = 0; i < 8; i++) m_busy[i] = 0;
      end else begin
        m_we = 0;
        if (g >= 0) begin
          a     = req_addr[g*3 +: 3];
          m_ptr = (g + 1) % 3;
          m_we  = (a != 0);
          m_wa  = int'(a);
          m_wd  = req_data[g*32 +: 32];
          if (g == 1 && a != 0) m_busy[a] = 0;
        end
        if (iss_valid && iss_long && iss_rd != 0 && !e_stall) m_busy[iss_rd] = 1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [2:0] rr_exp [6];
    int w;
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    iss_valid = 0; iss_long = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;

    // Reset behaviour
    tick();
    req_valid = 3'b111; iss_valid = 1; iss_rs1 = 3'd1;
    #1;
    check("rst_ready", req_ready, 3'b000);
    check("rst_stall", iss_stall, 1'b0);
    tick();
    reset = 0; req_valid = '0; iss_valid = 0; iss_rs1 = 0;
    #1;
    check("rst_we", rf_we, 1'b0);
    check("rst_wa", rf_wa, 3'd0);
    check("rst_wd", rf_wd, 32'd0);
    check("rst_busy", sb_busy, 8'h00);

    // ALU-only write
    tick();
    set_req(0, 3'd5, 32'hDEADBEEF); req_valid = 3'b001;
    #1 check("alu_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    #1;
    check("alu_we", rf_we, 1'b1);
    check("alu_wa", rf_wa, 3'd5);
    check("alu_wd", rf_wd, 32'hDEADBEEF);
    tick();
    #1;
    check("idle_we", rf_we, 1'b0);
    check("idle_wd_hold", rf_wd, 32'hDEADBEEF);

    // All three valid continuously from reset
    reset = 1;
    tick();
    reset = 0;
    set_req(0, 3'd1, 32'h11); set_req(1, 3'd2, 32'h22); set_req(2, 3'd4, 32'h44);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1 check($sformatf("rr_ready_%0d", c), req_ready, rr_exp[c]);
      tick();
    end
    req_valid = '0;

    // Load issue, dependent stall, release by LSU writeback
    iss_valid = 1; iss_long = 1; iss_rd = 3'd3; iss_rs1 = 0; iss_rs2 = 0;
    #1 check("ld_stall", iss_stall, 1'b0);
    tick();
    iss_valid = 0; iss_long = 0;
    #1 check("ld_busy", sb_busy, 8'h08);
    iss_valid = 1; iss_rs1 = 3'd3; iss_rd = 3'd6;
    #1 check("dep_stall", iss_stall, 1'b1);
    tick();
    #1 check("dep_stall_hold", iss_stall, 1'b1);
    set_req(1, 3'd3, 32'h55); req_valid = 3'b010;
    #1 check("lsu_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    w = 0;
    while (iss_stall && w < 4) begin
      tick();
      w++;
    end
    check("stall_drop", iss_stall, 1'b0);
    check("lsu_busy_clr", sb_busy, 8'h00);
    iss_valid = 0; iss_rs1 = 0; iss_rd = 0;

    // Simultaneous LSU clear and new load set on register 3
    tick();
    set_req(1, 3'd3, 32'h66); req_valid = 3'b010;
    iss_valid = 1; iss_long = 1; iss_rd = 3'd3;
    #1;
    check("sim_ready", req_ready, 3'b010);
    check("sim_stall", iss_stall, 1'b0);
    tick();
    req_valid = '0; iss_valid = 0; iss_long = 0; iss_rd = 0;
    #1 check("sim_busy", sb_busy, 8'h08);
    set_req(1, 3'd3, 32'h77); req_valid = 3'b010;
    tick();
    req_valid = '0;
    #1 check("clr_busy", sb_busy, 8'h00);

    // Debug write to register 0
    set_req(2, 3'd0, 32'h1); req_valid = 3'b100;
    #1 check("dbg_ready", req_ready, 3'b100);
    tick();
    req_valid = '0;
    #1 check("dbg_we", rf_we, 1'b0);

    // Reset the cycle after a grant
    iss_valid = 1; iss_long = 1; iss_rd = 3'd5;
    tick();
    iss_valid = 0; iss_long = 0; iss_rd = 0;
    set_req(0, 3'd2, 32'hAB); req_valid = 3'b001;
    #1 check("pre_busy", sb_busy, 8'h20);
    tick();
    req_valid = '0; reset = 1;
    #1 check("pre_we", rf_we, 1'b1);
    tick();
    reset = 0;
    #1;
    check("rst2_we", rf_we, 1'b0);
    check("rst2_busy", sb_busy, 8'h00);
    req_valid = 3'b111;
    #1 check("rst2_ptr_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
